// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between numReq valid/ready producers.
// Optional macro FIFO_ARB_BURST_EN keeps a grant for up to maxBurst words; without it every write releases.
module fifo_write_arbiter #(
  parameter int dataWidth = 8,
  parameter int numReq    = 4,
  parameter int maxBurst  = 4
) (
  input  logic                          clkIn,
  input  logic                          rstIn,
  input  logic [numReq-1:0]             reqValidIn,
  input  logic [numReq*dataWidth-1:0]   reqDataIn,
  output logic [numReq-1:0]             reqReadyOut,
  input  logic                          fifoFullIn,
  output logic [dataWidth-1:0]          fifoDataOut,
  output logic                          fifoWriteEnableOut,
  output logic [numReq-1:0]             grantOut,
  output logic                          busyOut
);

  localparam int PtrW = (numReq > 1) ? $clog2(numReq) : 1;
  localparam int CntW = $clog2(maxBurst + 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [numReq-1:0]      grant_q, grant_d;
  logic [PtrW-1:0]        last_ptr_q, last_ptr_d;
  logic [CntW-1:0]        burst_cnt_q, burst_cnt_d;

  logic [PtrW-1:0]        owner_idx;
  logic                   owner_valid;
  logic [dataWidth-1:0]   owner_data;
  logic [PtrW-1:0]        pick_idx;
  logic [PtrW-1:0]        cand;
  logic                   pick_ok;
  logic                   wr_en;
  logic                   last_word;

  always_comb begin
    owner_idx   = '0;
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < numReq; i++) begin
      if (grant_q[i]) begin
        owner_idx   = PtrW'(i);
        owner_valid = reqValidIn[i];
        owner_data  = reqDataIn[i*dataWidth +: dataWidth];
      end
    end
  end

  // Walk forward from the last owner so the previous winner is considered last.
  always_comb begin
    pick_idx = '0;
    pick_ok  = 1'b0;
    cand     = last_ptr_q;
    for (int k = 0; k < numReq; k++) begin
      cand = (cand == PtrW'(numReq - 1)) ? '0 : cand + 1'b1;
      if (!pick_ok && reqValidIn[cand]) begin
        pick_ok  = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign busyOut            = (state_q == BURST);
  assign wr_en              = busyOut & owner_valid & ~fifoFullIn;
  assign fifoWriteEnableOut = wr_en;
  assign fifoDataOut        = wr_en ? owner_data : '0;
  assign reqReadyOut        = (busyOut && !fifoFullIn) ? grant_q : '0;
  assign grantOut           = grant_q;

`ifdef FIFO_ARB_BURST_EN
  assign last_word = (burst_cnt_q == CntW'(maxBurst - 1));
`else
  assign last_word = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_ptr_d  = last_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_ok) begin
          state_d     = BURST;
          grant_d     = {{(numReq-1){1'b0}}, 1'b1} << pick_idx;
          burst_cnt_d = '0;
        end
      end
      BURST: begin
        // A stalled owner (full FIFO) keeps its grant; dropping valid forfeits it.
        if (!owner_valid || (wr_en && last_word)) begin
          state_d     = IDLE;
          grant_d     = '0;
          last_ptr_d  = owner_idx;
          burst_cnt_d = '0;
        end else if (wr_en) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_ptr_q  <= PtrW'(numReq - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_ptr_q  <= last_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule
